// File: rtl/pipeline_ctrl_unit_pkg.sv
// Shared types for the pipeline control unit: pipe state encoding,
// register specifier type and inter-stage latch indices.
package pipeline_ctrl_unit_pkg;

    typedef logic [4:0] regbits_t;

    typedef enum logic [1:0] {
        PS_RUN    = 2'b00,
        PS_DRAIN  = 2'b01,
        PS_HALTED = 2'b10
    } pipe_state_t;

    localparam int LAT_IFID  = 0;
    localparam int LAT_IDEX  = 1;
    localparam int LAT_EXMEM = 2;

endpackage

// File: rtl/pipeline_ctrl_unit_if.sv
// Hazard-source bundle from decoder, EX and the caches into the control unit.
// master = pipeline datapath side, slave = pipeline_ctrl_unit.
interface pipeline_ctrl_unit_if #(
    parameter int REG_W = 5
);
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_uses_rt;
    logic             id_halt;
    logic [REG_W-1:0] ex_rd;
    logic             ex_memread;
    logic             branch_taken;
    logic             ihit;
    logic             dmem_req;
    logic             dhit;

    modport master (
        output id_rs, id_rt, id_uses_rt, id_halt, ex_rd, ex_memread,
               branch_taken, ihit, dmem_req, dhit
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, id_halt, ex_rd, ex_memread,
               branch_taken, ihit, dmem_req, dhit
    );
endinterface

// File: rtl/pipeline_ctrl_unit_hazard.sv
// Combinational hazard detection: load-use interlock and data-cache wait.
module pipe_hazard_detect #(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_memread,
    input  logic             dmem_req,
    input  logic             dhit,
    output logic             loaduse,
    output logic             dwait
);
    logic w_rs_match;
    logic w_rt_match;

    // Register 0 is hardwired, so a load targeting it never creates a hazard.
    assign w_rs_match = (ex_rd == id_rs);
    assign w_rt_match = id_uses_rt && (ex_rd == id_rt);
    assign loaduse    = ex_memread && (ex_rd != '0) && (w_rs_match || w_rt_match);
    assign dwait      = dmem_req && !dhit;
endmodule

// File: rtl/pipeline_ctrl_unit.sv
// Pipeline control: per-latch enable/flush, PC enable and halt drain FSM.
// Define PIPE_PERF_CNT_EN to build the stall/flush performance counters.
module pipeline_ctrl_unit
    import pipeline_ctrl_unit_pkg::*;
#(
    parameter int NSTAGES = 5,
    parameter int REG_W   = 5,
    parameter int CNT_W   = 32,
    localparam int NLATCH = NSTAGES - 1
) (
    input  logic              CLK,
    input  logic              RST,
    pipeline_ctrl_unit_if.slave bus,
    output logic              pc_en,
    output logic [NLATCH-1:0] latch_en,
    output logic [NLATCH-1:0] latch_flush,
    output logic              halt,
    output pipe_state_t       state,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_events
);
    localparam int DCW = $clog2(NSTAGES);

    pipe_state_t    r_state, w_state_nxt;
    logic [DCW-1:0] r_cnt, w_cnt_nxt;
    logic           w_loaduse;
    logic           w_dwait;

    pipe_hazard_detect #(.REG_W(REG_W)) u_hazard (
        .id_rs      (bus.id_rs),
        .id_rt      (bus.id_rt),
        .id_uses_rt (bus.id_uses_rt),
        .ex_rd      (bus.ex_rd),
        .ex_memread (bus.ex_memread),
        .dmem_req   (bus.dmem_req),
        .dhit       (bus.dhit),
        .loaduse    (w_loaduse),
        .dwait      (w_dwait)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= PS_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        pc_en       = 1'b0;
        latch_en    = '0;
        latch_flush = '0;
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            PS_RUN: begin
                if (w_dwait) begin
                    // full freeze: defaults already hold everything
                end else if (bus.branch_taken) begin
                    pc_en                 = 1'b1;
                    latch_en              = '1;
                    latch_flush[LAT_IFID] = 1'b1;
                    latch_flush[LAT_IDEX] = 1'b1;
                end else if (w_loaduse) begin
                    // HALT stuck behind a load-use stall is retried once it clears
                    latch_en              = '1;
                    latch_en[LAT_IFID]    = 1'b0;
                    latch_flush[LAT_IDEX] = 1'b1;
                end else begin
                    latch_en = '1;
                    if (bus.ihit) begin
                        pc_en = 1'b1;
                    end else begin
                        latch_flush[LAT_IFID] = 1'b1;
                    end
                    if (bus.id_halt) begin
                        pc_en                 = 1'b0;
                        latch_flush[LAT_IFID] = 1'b1;
                        w_state_nxt           = PS_DRAIN;
                        w_cnt_nxt             = DCW'(NSTAGES - 2);
                    end
                end
            end
            PS_DRAIN: begin
                if (!w_dwait) begin
                    latch_en              = '1;
                    latch_flush[LAT_IFID] = 1'b1;
                    if (r_cnt == DCW'(1)) begin
                        w_state_nxt = PS_HALTED;
                    end else begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end
                end
            end
            PS_HALTED: begin
            end
            default: begin
                w_state_nxt = PS_RUN;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign halt  = (r_state == PS_HALTED);
    assign state = r_state;

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_flush_events;
    logic             w_stall;
    logic             w_squash;

    assign w_stall  = (r_state == PS_RUN) && !pc_en;
    assign w_squash = (r_state == PS_RUN) && !w_dwait && bus.branch_taken;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_stall_cycles <= '0;
            r_flush_events <= '0;
        end else begin
            if (w_stall && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + 1'b1;
            end
            if (w_squash && (r_flush_events != '1)) begin
                r_flush_events <= r_flush_events + 1'b1;
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_events = r_flush_events;
`else
    assign stall_cycles = '0;
    assign flush_events = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl_unit.sv
// Directed bench for pipeline_ctrl_unit (NSTAGES=5): hazards, halt drain, reset, counters.
module tb_pipeline_ctrl_unit;
    import pipeline_ctrl_unit_pkg::*;

    localparam int NSTAGES = 5;
    localparam int NLATCH  = NSTAGES - 1;
    localparam int CNT_W   = 32;

    logic              CLK;
    logic              RST;
    logic              pc_en;
    logic [NLATCH-1:0] latch_en;
    logic [NLATCH-1:0] latch_flush;
    logic              halt;
    pipe_state_t       state;
    logic [CNT_W-1:0]  stall_cycles;
    logic [CNT_W-1:0]  flush_events;

    int checks   = 0;
    int failures = 0;

    pipeline_ctrl_unit_if #(.REG_W(5)) bus ();

    pipeline_ctrl_unit #(.NSTAGES(NSTAGES), .REG_W(5), .CNT_W(CNT_W)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .bus          (bus.slave),
        .pc_en        (pc_en),
        .latch_en     (latch_en),
        .latch_flush  (latch_flush),
        .halt         (halt),
        .state        (state),
        .stall_cycles (stall_cycles),
        .flush_events (flush_events)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Step to 2 time units after the next rising edge.
    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.id_rs        = '0;
        bus.id_rt        = '0;
        bus.id_uses_rt   = 1'b0;
        bus.id_halt      = 1'b0;
        bus.ex_rd        = '0;
        bus.ex_memread   = 1'b0;
        bus.branch_taken = 1'b0;
        bus.ihit         = 1'b1;
        bus.dmem_req     = 1'b0;
        bus.dhit         = 1'b0;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        #1;
    endtask

    initial begin
        idle_inputs();
        do_reset();

        // Reset state
        chk("rst_state", state, PS_RUN);
        chk("rst_halt", halt, 1'b0);
        chk("rst_pc_en", pc_en, 1'b1);
        chk("rst_latch_en", latch_en, 4'b1111);
        chk("rst_flush", latch_flush, 4'b0000);
        chk("rst_stall_cnt", stall_cycles, 32'd0);
        chk("rst_flush_cnt", flush_events, 32'd0);

        // Load-use on rs
        bus.ex_memread = 1'b1; bus.ex_rd = 5'd8; bus.id_rs = 5'd8;
        #1;
        chk("lu_rs_pc_en", pc_en, 1'b0);
        chk("lu_rs_latch_en", latch_en, 4'b1110);
        chk("lu_rs_flush", latch_flush, 4'b0010);
        // Load to r0 never stalls
        bus.ex_rd = 5'd0; bus.id_rs = 5'd0;
        #1;
        chk("lu_r0_pc_en", pc_en, 1'b1);
        chk("lu_r0_flush", latch_flush, 4'b0000);
        // Load-use on rt only when rt is read
        bus.ex_rd = 5'd9; bus.id_rs = 5'd3; bus.id_rt = 5'd9; bus.id_uses_rt = 1'b1;
        #1;
        chk("lu_rt_pc_en", pc_en, 1'b0);
        chk("lu_rt_flush", latch_flush, 4'b0010);
        bus.id_uses_rt = 1'b0;
        #1;
        chk("lu_rt_unused_pc_en", pc_en, 1'b1);

        // Branch beats load-use and HALT
        bus.id_uses_rt = 1'b1; bus.branch_taken = 1'b1; bus.id_halt = 1'b1;
        #1;
        chk("br_pc_en", pc_en, 1'b1);
        chk("br_latch_en", latch_en, 4'b1111);
        chk("br_flush", latch_flush, 4'b0011);
        tick();
        chk("br_state", state, PS_RUN);
        idle_inputs();

        // Instruction fetch miss
        bus.ihit = 1'b0;
        #1;
        chk("imiss_pc_en", pc_en, 1'b0);
        chk("imiss_flush0", latch_flush[0], 1'b1);
        chk("imiss_en_hi", latch_en[3:1], 3'b111);
        bus.ihit = 1'b1;

        // D-cache wait for three cycles, then hit
        bus.dmem_req = 1'b1; bus.dhit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("dwait%0d_pc_en", i), pc_en, 1'b0);
            chk($sformatf("dwait%0d_latch_en", i), latch_en, 4'b0000);
            chk($sformatf("dwait%0d_flush", i), latch_flush, 4'b0000);
            tick();
        end
        bus.dhit = 1'b1;
        #1;
        chk("dhit_pc_en", pc_en, 1'b1);
        chk("dhit_latch_en", latch_en, 4'b1111);
        idle_inputs();

        // Halt drain without wait: accepted at edge t, halt from t+3
        do_reset();
        bus.id_halt = 1'b1;
        #1;
        chk("hacc_pc_en", pc_en, 1'b0);
        chk("hacc_flush0", latch_flush[0], 1'b1);
        tick();
        bus.id_halt = 1'b0;
        chk("h_t0_state", state, PS_DRAIN);
        chk("h_t0_halt", halt, 1'b0);
        chk("h_t0_pc_en", pc_en, 1'b0);
        chk("h_t0_en_hi", latch_en[3:1], 3'b111);
        tick();
        bus.branch_taken = 1'b1; bus.ihit = 1'b0;
        #1;
        chk("h_t1_br_ignored", latch_flush, 4'b0001);
        chk("h_t1_pc_en", pc_en, 1'b0);
        chk("h_t1_halt", halt, 1'b0);
        tick();
        chk("h_t2_halt", halt, 1'b0);
        chk("h_t2_state", state, PS_DRAIN);
        tick();
        chk("h_t3_halt", halt, 1'b1);
        chk("h_t3_state", state, PS_HALTED);
        chk("h_t3_pc_en", pc_en, 1'b0);
        chk("h_t3_latch_en", latch_en, 4'b0000);
        idle_inputs();
        tick();
        chk("h_absorb_halt", halt, 1'b1);
        chk("h_absorb_pc_en", pc_en, 1'b0);

        // Halt drain with two D-cache wait cycles: halt from t+5
        do_reset();
        bus.id_halt = 1'b1;
        tick();
        bus.id_halt = 1'b0;
        bus.dmem_req = 1'b1; bus.dhit = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk($sformatf("hw_wait%0d_latch_en", i), latch_en, 4'b0000);
            chk($sformatf("hw_wait%0d_pc_en", i), pc_en, 1'b0);
            tick();
            chk($sformatf("hw_wait%0d_state", i), state, PS_DRAIN);
        end
        bus.dmem_req = 1'b0;
        tick();
        chk("hw_t3_halt", halt, 1'b0);
        tick();
        chk("hw_t4_halt", halt, 1'b0);
        tick();
        chk("hw_t5_halt", halt, 1'b1);
        idle_inputs();

        // Reset in the middle of the drain
        do_reset();
        bus.id_halt = 1'b1;
        tick();
        bus.id_halt = 1'b0;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        #1;
        chk("rmd_state", state, PS_RUN);
        chk("rmd_halt", halt, 1'b0);
        chk("rmd_pc_en", pc_en, 1'b1);

        // Performance counters: four load-use stalls then two branch squashes
        do_reset();
        bus.ex_memread = 1'b1; bus.ex_rd = 5'd4; bus.id_rs = 5'd4;
        for (int i = 0; i < 4; i++) tick();
        idle_inputs();
        bus.branch_taken = 1'b1;
        for (int i = 0; i < 2; i++) tick();
        idle_inputs();
        #1;
`ifdef PIPE_PERF_CNT_EN
        chk("perf_stall_cycles", stall_cycles, 32'd4);
        chk("perf_flush_events", flush_events, 32'd2);
`else
        chk("perf_stall_cycles", stall_cycles, 32'd0);
        chk("perf_flush_events", flush_events, 32'd0);
`endif
        RST = 1'b1;
        tick();
        RST = 1'b0;
        #1;
        chk("perf_rst_stall", stall_cycles, 32'd0);
        chk("perf_rst_flush", flush_events, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
